data_input: RTL and testbench

DATA_INPUT -- requirements
Module: data_input

---
 rtl/data_input_pkg.sv | 13 +
 rtl/io_fifo.sv | 37 +++
 rtl/data_input.sv | 80 ++++++++
 tb/tb_data_input.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_input_pkg.sv
// data_input_pkg: shared FSM state type, default I/O addresses and status-word layout.
package data_input_pkg;
  typedef enum logic [1:0] {WAIT_LOW, IDLE, ACK} state_e;
  localparam logic [9:0] ADDR_DATA_DEF = 10'd0;
  localparam logic [9:0] ADDR_STATUS_DEF = 10'd1;
  // Status word: count in [clog2(depth):0], then empty, then full.
  function automatic int status_empty_bit(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int status_full_bit(input int depth);
    return $clog2(depth) + 2;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: power-of-two circular buffer; callers guarantee no push when full or pop when empty.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clock)
    if (push_i) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o = count_q == CW'(DEPTH);
endmodule

// File: rtl/data_input.sv
// data_input: four-phase device capture into io_fifo, drained by processor I/O reads.
// Optional status word at ADDR_STATUS when DATA_INPUT_STATUS_EN is defined.
module data_input
  import data_input_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [9:0] ADDR_DATA = ADDR_DATA_DEF,
  parameter logic [9:0] ADDR_STATUS = ADDR_STATUS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ext_data,
  input  logic        ext_req,
  output logic        ext_ack,
  input  logic        IO_RAMread,
  input  logic [9:0]  address,
  output logic [31:0] IO_RAMInput,
  output logic        inputWait
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef DATA_INPUT_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif
  logic [1:0] sync_q, prime_q;
  logic req_s, push, pop, data_hit, status_hit, empty, full;
  state_e state_q, state_d;
  logic [31:0] head, status_word, rdata_d, rdata_q;
  logic [CW-1:0] count;
  assign req_s = sync_q[1];
  // prime_q masks the reset value of the synchronizer so a held-high request is not mistaken for a low.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync_q <= '0;
      prime_q <= '0;
      state_q <= WAIT_LOW;
      rdata_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ext_req};
      prime_q <= {prime_q[0], 1'b1};
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  always_comb begin
    state_d = state_q;
    push = 1'b0;
    case (state_q)
      WAIT_LOW: if (prime_q[1] && !req_s) state_d = IDLE;
      IDLE: if (req_s && !full) begin
        push = 1'b1;
        state_d = ACK;
      end
      ACK: if (!req_s) state_d = IDLE;
      default: state_d = WAIT_LOW;
    endcase
  end
  assign ext_ack = state_q == ACK;
  assign data_hit = address == ADDR_DATA;
  assign status_hit = STATUS_EN && address == ADDR_STATUS;
  assign inputWait = IO_RAMread && data_hit && empty;
  assign pop = IO_RAMread && data_hit && !empty;
  assign status_word = 32'(count) | (32'(empty) << status_empty_bit(DEPTH))
                     | (32'(full) << status_full_bit(DEPTH));
  always_comb begin
    rdata_d = !IO_RAMread ? rdata_q : data_hit ? (empty ? rdata_q : head) : status_hit ? status_word : '0;
  end
  assign IO_RAMInput = rdata_q;
  io_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .wdata_i(ext_data),
    .rdata_o(head),
    .count_o(count),
    .empty_o(empty),
    .full_o(full)
  );
endmodule

// File: tb/tb_data_input.sv
// tb_data_input: scoreboard bench for data_input; device words queued on send, checked on read.
module tb_data_input;
  import data_input_pkg::*;
  logic clock = 1'b0, reset = 1'b0, ext_req = 1'b0, ext_ack, IO_RAMread = 1'b0, inputWait;
  logic [31:0] ext_data = '0, IO_RAMInput;
  logic [9:0] address = '0;
  logic [31:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  always #5 clock = ~clock;
  data_input dut (
    .clock(clock), .reset(reset), .ext_data(ext_data), .ext_req(ext_req), .ext_ack(ext_ack),
    .IO_RAMread(IO_RAMread), .address(address), .IO_RAMInput(IO_RAMInput), .inputWait(inputWait)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic wait_ack(input logic lvl, input string tag, output int n);
    n = 0;
    do begin tick; n++; end while (ext_ack !== lvl && n < 30);
    chk(tag, ext_ack, lvl);
  endtask
  task automatic send(input logic [31:0] d, output int up, output int dn);
    exp_q.push_back(d);
    ext_data = d;
    ext_req = 1'b1;
    wait_ack(1'b1, "ack_rise", up);
    ext_req = 1'b0;
    wait_ack(1'b0, "ack_fall", dn);
  endtask
  task automatic rd(input string tag, output int stalls);
    logic [31:0] e;
    stalls = 0;
    IO_RAMread = 1'b1;
    address = ADDR_DATA_DEF;
    #1;
    while (inputWait && stalls < 50) begin tick; stalls++; end
    chk({tag, "_wait"}, inputWait, 1'b0);
    tick;
    IO_RAMread = 1'b0;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk(tag, IO_RAMInput, e);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int up, dn, st;
    logic [31:0] e;
    #3;
    chk("rst_ack", ext_ack, 1'b0);
    chk("rst_rdata", IO_RAMInput, 32'h0);
    repeat (2) tick;
    reset = 1'b1;
    repeat (4) tick;
    // single transfer with handshake latency
    send(32'hCAFE0001, up, dn);
    chk("t1_up_lat", up, 3);
    chk("t1_dn_lat", dn, 3);
    rd("t1_data", st);
    // stalled read satisfied by a later device transfer
    fork
      rd("stall_data", st);
      send(32'h5, up, dn);
    join
    chk("stall_seen", st >= 2, 1'b1);
    repeat (3) tick;
    chk("idle_hold", IO_RAMInput, 32'h5);
    IO_RAMread = 1'b1;
    address = 10'd7;
    tick;
    IO_RAMread = 1'b0;
    chk("other_addr", IO_RAMInput, 32'h0);
    // full FIFO blocks the fifth request until a read frees a slot
    for (int i = 1; i <= 4; i++) send(32'(i), up, dn);
    exp_q.push_back(32'h5);
    ext_data = 32'h5;
    ext_req = 1'b1;
    repeat (8) tick;
    chk("full_noack", ext_ack, 1'b0);
    rd("full_r1", st);
    wait_ack(1'b1, "full_ack", up);
    ext_req = 1'b0;
    wait_ack(1'b0, "full_ack_fall", dn);
    for (int i = 0; i < 4; i++) rd("full_drain", st);
    // push and pop on the same edge
    send(32'h11, up, dn);
    send(32'h22, up, dn);
    exp_q.push_back(32'h33);
    ext_data = 32'h33;
    ext_req = 1'b1;
    tick;
    tick;
    IO_RAMread = 1'b1;
    address = ADDR_DATA_DEF;
    #1;
    chk("sim_wait", inputWait, 1'b0);
    tick;
    IO_RAMread = 1'b0;
    chk("sim_ack", ext_ack, 1'b1);
    e = exp_q.pop_front();
    chk("sim_pop", IO_RAMInput, e);
    ext_req = 1'b0;
    wait_ack(1'b0, "sim_ack_fall", dn);
    rd("sim_b", st);
    rd("sim_c", st);
    IO_RAMread = 1'b1;
    #1;
    chk("sim_empty", inputWait, 1'b1);
    IO_RAMread = 1'b0;
    // status word with three queued words
    for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), up, dn);
    IO_RAMread = 1'b1;
    address = ADDR_STATUS_DEF;
    tick;
    IO_RAMread = 1'b0;
`ifdef DATA_INPUT_STATUS_EN
    chk("status", IO_RAMInput, 32'h3);
`else
    chk("status", IO_RAMInput, 32'h0);
`endif
    for (int i = 0; i < 3; i++) rd("status_drain", st);
    // reset mid-ACK with request held high
    ext_data = 32'h77;
    ext_req = 1'b1;
    wait_ack(1'b1, "rst_pre_ack", up);
    reset = 1'b0;
    #1;
    chk("midrst_ack", ext_ack, 1'b0);
    chk("midrst_rdata", IO_RAMInput, 32'h0);
    tick;
    reset = 1'b1;
    repeat (10) tick;
    chk("midrst_noack", ext_ack, 1'b0);
    IO_RAMread = 1'b1;
    address = ADDR_DATA_DEF;
    #1;
    chk("midrst_empty", inputWait, 1'b1);
    IO_RAMread = 1'b0;
    ext_req = 1'b0;
    repeat (5) tick;
    send(32'h88, up, dn);
    rd("midrst_new", st);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
